press_classifier: RTL and testbench

//   Consumes the debouncer's clean level and one-cycle rising-edge pulse for one button.

---
 rtl/press_classifier_if.sv | 28 ++
 rtl/press_classifier.sv | 129 ++++++++++++
 tb/tb_press_classifier.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/press_classifier_if.sv
// Button-event bus between a per-button debouncer and the press classifier.
// The master drives the debounced level/edge; the slave returns registered event pulses.
interface press_classifier_if;
    logic btn_level;
    logic btn_rise;
    logic short_press;
    logic long_press;
    logic repeat_tick;
    logic held;

    modport master (
        output btn_level,
        output btn_rise,
        input  short_press,
        input  long_press,
        input  repeat_tick,
        input  held
    );

    modport slave (
        input  btn_level,
        input  btn_rise,
        output short_press,
        output long_press,
        output repeat_tick,
        output held
    );
endinterface

// File: rtl/press_classifier.sv
// Classifies a debounced button press as short or long, with optional auto-repeat ticks.
// Define AUTO_REPEAT_EN to build the repeat counter; otherwise repeat_tick is tied low.
module press_classifier #(
    parameter int unsigned LONG_CYCLES   = 10_000_000,
    parameter int unsigned REPEAT_CYCLES = 2_500_000,
    parameter int unsigned CNT_W         = 24
) (
    input logic              clk,
    input logic              rst_n,
    press_classifier_if.slave bus
);

    if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cycles
        $error("press_classifier: LONG_CYCLES and REPEAT_CYCLES must be >= 2");
    end
    if (CNT_W < 32 && (LONG_CYCLES > (32'd1 << CNT_W) || REPEAT_CYCLES > (32'd1 << CNT_W)))
    begin : g_bad_width
        $error("press_classifier: CNT_W too narrow for the cycle thresholds");
    end

    typedef enum logic [1:0] {
        StIdle,
        StPressed,
        StLong
    } state_e;

    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             held_q, held_d;
    logic             rep_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                // A level without an accepted edge (held through reset) never starts a press.
                if (bus.btn_rise && bus.btn_level) begin
                    state_d = StPressed;
                    cnt_d   = '0;
                end
            end
            StPressed: begin
                // Release beats a coincident threshold hit.
                if (!bus.btn_level) begin
                    short_d = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == LongLast) begin
                    long_d  = 1'b1;
                    state_d = StLong;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StLong: begin
                if (!bus.btn_level) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
`ifdef AUTO_REPEAT_EN
                    if (cnt_q == CNT_W'(REPEAT_CYCLES - 1)) begin
                        rep_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            short_q <= 1'b0;
            long_q  <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            short_q <= short_d;
            long_q  <= long_d;
            held_q  <= held_d;
        end
    end

`ifdef AUTO_REPEAT_EN
    logic rep_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_q <= 1'b0;
        end else begin
            rep_q <= rep_d;
        end
    end

    assign bus.repeat_tick = rep_q;
`else
    logic unused_rep;
    assign unused_rep      = rep_d;
    assign bus.repeat_tick = 1'b0;
`endif

    assign bus.short_press = short_q;
    assign bus.long_press  = long_q;
    assign bus.held        = held_q;

endmodule

// File: tb/tb_press_classifier.sv
// Randomized and directed checks of press_classifier against a timestamp-based press model.
module tb_press_classifier;
    localparam int unsigned LongCycles   = 8;
    localparam int unsigned RepeatCycles = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    press_classifier_if bus ();

    press_classifier #(
        .LONG_CYCLES  (LongCycles),
        .REPEAT_CYCLES(RepeatCycles),
        .CNT_W        (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model: remembers the edge index where the press was accepted and where long fired.
    bit         m_active;
    bit         m_longed;
    int         ecnt;
    int         t_accept;
    int         t_long;
    logic [3:0] exp_vec;  // {short, long, repeat, held}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_longed = 1'b0;
        exp_vec  = 4'b0000;
    endtask

    task automatic model_step(input logic lvl, input logic rise);
        logic s, l, r;
        s = 1'b0; l = 1'b0; r = 1'b0;
        ecnt++;
        if (!m_active) begin
            if (rise && lvl) begin
                m_active = 1'b1;
                m_longed = 1'b0;
                t_accept = ecnt;
            end
        end else if (!lvl) begin
            s        = !m_longed;
            m_active = 1'b0;
        end else if (!m_longed) begin
            if (ecnt - t_accept == int'(LongCycles)) begin
                l        = 1'b1;
                m_longed = 1'b1;
                t_long   = ecnt;
            end
        end else begin
`ifdef AUTO_REPEAT_EN
            r = ((ecnt - t_long) % int'(RepeatCycles)) == 0;
`endif
        end
        exp_vec = {s, l, r, m_active};
    endtask

    function automatic logic [3:0] dut_vec();
        return {bus.short_press, bus.long_press, bus.repeat_tick, bus.held};
    endfunction

    task automatic cycle(input logic lvl, input logic rise);
        bus.btn_level = lvl;
        bus.btn_rise  = rise;
        @(posedge clk);
        model_step(lvl, rise);
        #1;
        check("outputs", 32'(dut_vec()), 32'(exp_vec));
        check("onehot_pulses", 32'($onehot0({bus.short_press, bus.long_press, bus.repeat_tick})),
              32'd1);
    endtask

    // Assert reset mid-cycle; outputs must clear without waiting for a clock edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_async_clear", 32'(dut_vec()), 32'd0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic lvl;
    int   lp_at;
    int   nrep;
    int   npulse;
    int   nheld;

    initial begin
        bus.btn_level = 1'b1;
        bus.btn_rise  = 1'b0;
        ecnt = 0;
        model_reset();
        rst_n = 1'b0;
        #1;
        check("reset_state", 32'(dut_vec()), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Button held through reset with no rise: no events.
        npulse = 0; nheld = 0;
        for (int i = 0; i < 50; i++) begin
            cycle(1'b1, 1'b0);
            npulse += int'(bus.short_press) + int'(bus.long_press) + int'(bus.repeat_tick);
            nheld  += int'(bus.held);
        end
        check("powerup_held_no_pulse", 32'(npulse), 32'd0);
        check("powerup_held_no_held", 32'(nheld), 32'd0);
        cycle(1'b0, 1'b0);

        // Short press: rise, level high two more edges, then low.
        cycle(1'b1, 1'b1);
        check("short_held_on", 32'(bus.held), 32'd1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("short_pulse", 32'(dut_vec()), 32'b1000);
        cycle(1'b0, 1'b0);
        check("short_one_cycle", 32'(dut_vec()), 32'b0000);

        // Long press held 20 edges after the rise.
        cycle(1'b1, 1'b1);
        lp_at = -1; nrep = 0; npulse = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 1'b0);
            if (bus.long_press) begin
                npulse++;
                if (lp_at < 0) lp_at = i;
            end
            nrep += int'(bus.repeat_tick);
        end
        check("long_timing", 32'(lp_at), 32'd8);
        check("long_once", 32'(npulse), 32'd1);
`ifdef AUTO_REPEAT_EN
        check("repeat_count", 32'(nrep), 32'd3);
`else
        check("repeat_count", 32'(nrep), 32'd0);
`endif
        cycle(1'b0, 1'b0);
        check("long_release_silent", 32'(dut_vec()), 32'b0000);

        // Boundary: release on the very edge the threshold would hit.
        cycle(1'b1, 1'b1);
        for (int i = 1; i <= 7; i++) cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("boundary_short_only", 32'(dut_vec()), 32'b1000);
        cycle(1'b0, 1'b0);

        // Spurious rises mid-press must not restart the long timer.
        cycle(1'b1, 1'b1);
        lp_at = -1;
        for (int i = 1; i <= 12; i++) begin
            cycle(1'b1, (i == 3 || i == 10));
            if (bus.long_press && lp_at < 0) lp_at = i;
        end
        check("spurious_long_timing", 32'(lp_at), 32'd8);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);
        check("idle_rise_no_level", 32'(bus.held), 32'd0);

        // Reset during LONG with the button still held.
        cycle(1'b1, 1'b1);
        for (int i = 1; i <= 10; i++) cycle(1'b1, 1'b0);
        do_reset();
        npulse = 0; nheld = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0);
            npulse += int'(bus.short_press) + int'(bus.long_press) + int'(bus.repeat_tick);
            nheld  += int'(bus.held);
        end
        check("post_reset_silent", 32'(npulse + nheld), 32'd0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        check("post_reset_new_rise", 32'(bus.held), 32'd1);
        cycle(1'b0, 1'b0);

        // Random segments of level with mostly-aligned and occasional spurious rises.
        lvl = 1'b0;
        for (int seg = 0; seg < 200; seg++) begin
            int len;
            lvl = ~lvl;
            len = int'($urandom_range(1, 24));
            for (int i = 0; i < len; i++) begin
                logic rise;
                if (i == 0 && lvl) rise = ($urandom_range(0, 7) != 0);
                else rise = ($urandom_range(0, 15) == 0);
                cycle(lvl, rise);
            end
            if ($urandom_range(0, 40) == 0) do_reset();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
